// File: rtl/mem_access_stage_pkg.sv
// Shared processor definitions for the memory-access pipeline stage:
// FSM encoding, latency default, data-memory geometry and the latched EX/MEM op.
package mem_access_stage_pkg;

  localparam int MEM_LATENCY_DEF = 2;
  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 16;
  localparam int REG_W           = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              reg_dst;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              reg_write;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } ex_mem_t;

  function automatic logic [REG_W-1:0] dest_reg(input ex_mem_t op);
    return op.reg_dst ? op.rd : op.rt;
  endfunction

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Data memory: synchronous write and synchronous read, one shared address port.
// Contents are deliberately not reset.
module data_mem
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registered pass-through for ALU ops, multi-cycle load/store
// (MEM_LATENCY 1..15) with a combinational stall request back to IF/ID/EX.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              RegDst_in,
  input  logic              MemRead_in,
  input  logic              MemtoReg_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] read_data2_in,
  input  logic [15:0]       lsadr_in,
  output logic              mem_busy,
  output logic              wb_valid,
  output logic              RegWrite_out,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ex_mem_t           op_q, op_d, in_op;
  logic              wb_valid_q, wb_valid_d;
  logic              rw_q, rw_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] rdata, wb_data_cur;
  logic              last, mem_we, mem_re, load_sel;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^lsadr_in[15:ADDR_W];

  assign in_op = '{reg_dst: RegDst_in, mem_read: MemRead_in, mem_to_reg: MemtoReg_in,
                   mem_write: MemWrite_in, reg_write: RegWrite_in, rt: rt_in, rd: rd_in,
                   result: result_in, wdata: read_data2_in, addr: lsadr_in[ADDR_W-1:0]};

  // Store commit and load sample both land on the ACCESS->DONE edge; a store wins over a load.
  assign last     = (state_q == ACCESS) && (cnt_q == '0);
  assign mem_we   = last && op_q.mem_write;
  assign mem_re   = last && op_q.mem_read && !op_q.mem_write;
  assign load_sel = (state_q == DONE) && op_q.mem_to_reg && op_q.mem_read && !op_q.mem_write;

  // The loaded word only exists in the read register during DONE; afterwards it is held in wb_data_q.
  assign wb_data_cur = load_sel ? rdata : wb_data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    wb_valid_d = wb_valid_q;
    rw_d       = rw_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_cur;
    mem_busy   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (stall_in) begin
          wb_valid_d = 1'b0;
          rw_d       = 1'b0;
        end else if (MemRead_in || MemWrite_in) begin
          op_d       = in_op;
          cnt_d      = CNT_INIT;
          mem_busy   = 1'b1;
          wb_valid_d = 1'b0;
          rw_d       = 1'b0;
          state_d    = ACCESS;
        end else begin
          wb_valid_d = 1'b1;
          rw_d       = RegWrite_in;
          wb_reg_d   = dest_reg(in_op);
          wb_data_d  = result_in;
        end
      end
      ACCESS: begin
        // The final ACCESS cycle drops busy so upstream advances into the DONE cycle.
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - 1'b1;
          mem_busy = 1'b1;
        end else begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          rw_d       = op_q.reg_write && !(op_q.mem_read && op_q.mem_write);
          wb_reg_d   = dest_reg(op_q);
          wb_data_d  = op_q.result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      rw_q       <= rw_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  data_mem #(.DEPTH(MEM_DEPTH)) u_data_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (op_q.addr),
    .wdata_i (op_q.wdata),
    .rdata_o (rdata)
  );

  assign wb_valid     = wb_valid_q;
  assign RegWrite_out = rw_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_cur;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: write-back scoreboard plus stall, reset and latency checks.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, RegDst_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in;
  logic [3:0]  rt_in, rd_in;
  logic [15:0] result_in, read_data2_in, lsadr_in;

  logic        mem_busy, wb_valid, RegWrite_out;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        s1_busy, s1_wbv, s1_rw, s15_busy, s15_wbv, s15_rw;
  logic [3:0]  s1_reg, s15_reg;
  logic [15:0] s1_data, s15_data;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
    logic        w;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .RegDst_in(RegDst_in),
    .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .rt_in(rt_in), .rd_in(rd_in), .result_in(result_in),
    .read_data2_in(read_data2_in), .lsadr_in(lsadr_in), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .RegWrite_out(RegWrite_out), .wb_reg(wb_reg), .wb_data(wb_data));

  mem_access_stage #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .RegDst_in(RegDst_in),
    .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .rt_in(rt_in), .rd_in(rd_in), .result_in(result_in),
    .read_data2_in(read_data2_in), .lsadr_in(lsadr_in), .mem_busy(s1_busy),
    .wb_valid(s1_wbv), .RegWrite_out(s1_rw), .wb_reg(s1_reg), .wb_data(s1_data));

  mem_access_stage #(.MEM_LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .RegDst_in(RegDst_in),
    .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .rt_in(rt_in), .rd_in(rd_in), .result_in(result_in),
    .read_data2_in(read_data2_in), .lsadr_in(lsadr_in), .mem_busy(s15_busy),
    .wb_valid(s15_wbv), .RegWrite_out(s15_rw), .wb_reg(s15_reg), .wb_data(s15_data));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write-back of the main instance must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL wb_unexpected observed=valid reg=%0h data=%0h expected=none", wb_reg, wb_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wb_reg", {28'd0, wb_reg}, {28'd0, e.r});
        check("wb_data", {16'd0, wb_data}, {16'd0, e.d});
        check("wb_regwrite", {31'd0, RegWrite_out}, {31'd0, e.w});
      end
    end
  end

  task automatic idle_inputs();
    stall_in = 1'b1; RegDst_in = 1'b0; MemRead_in = 1'b0; MemtoReg_in = 1'b0;
    MemWrite_in = 1'b0; RegWrite_in = 1'b0; rt_in = '0; rd_in = '0;
    result_in = '0; read_data2_in = '0; lsadr_in = '0;
  endtask

  // ctl = {RegDst, MemRead, MemtoReg, MemWrite, RegWrite}
  task automatic drive(input logic [4:0] ctl, input logic [3:0] rt, input logic [3:0] rd,
                       input logic [15:0] res, input logic [15:0] wd, input logic [15:0] adr);
    stall_in = 1'b0;
    {RegDst_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in} = ctl;
    rt_in = rt; rd_in = rd; result_in = res; read_data2_in = wd; lsadr_in = adr;
  endtask

  // Holds the presented op while mem_busy, then advances one cycle like a real upstream stage.
  task automatic issue(input string tag, output int busy_cycles);
    bit done_f;
    busy_cycles = 0;
    done_f = 1'b0;
    for (int k = 0; k < 40 && !done_f; k++) begin
      @(negedge clk);
      if (mem_busy === 1'b1) begin
        busy_cycles++;
        @(posedge clk); #1;
      end else begin
        done_f = 1'b1;
      end
    end
    if (!done_f) begin
      total++; bad++;
      $error("FAIL %s_timeout observed=busy_forever expected=release", tag);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic op(input string tag, input logic [4:0] ctl, input logic [3:0] rt,
                    input logic [3:0] rd, input logic [15:0] res, input logic [15:0] wd,
                    input logic [15:0] adr, input logic [3:0] e_r, input logic [15:0] e_d,
                    input logic e_w, input int e_busy);
    int nb;
    sb.push_back('{r: e_r, d: e_d, w: e_w});
    drive(ctl, rt, rd, res, wd, adr);
    issue(tag, nb);
    check({tag, "_busy_cycles"}, nb, e_busy);
  endtask

  task automatic bubble(input int n);
    idle_inputs();
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("bubble_valid", {31'd0, wb_valid}, 32'd0);
      check("bubble_regwrite", {31'd0, RegWrite_out}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b1, b2, b15, f1, f2, f15;
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    check("rst_reg", {28'd0, wb_reg}, 32'd0);
    check("rst_data", {16'd0, wb_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through with RegDst selecting rd.
    op("pass1", 5'b10001, 4'd0, 4'd5, 16'h1234, 16'h0, 16'h0, 4'd5, 16'h1234, 1'b1, 0);
    @(negedge clk);
    check("pass1_valid", {31'd0, wb_valid}, 32'd1);
    check("pass1_busy_low", {31'd0, mem_busy}, 32'd0);
    bubble(3);
    op("pass2", 5'b00000, 4'd9, 4'd2, 16'hA5A5, 16'h0, 16'h0, 4'd9, 16'hA5A5, 1'b0, 0);

    // Store then back-to-back load; address 0x0110 wraps onto 0x10.
    op("sw_beef", 5'b00010, 4'd1, 4'd0, 16'h0110, 16'hBEEF, 16'h0110, 4'd1, 16'h0110, 1'b0, 2);
    op("lw_beef", 5'b01101, 4'd3, 4'd8, 16'h0110, 16'h0, 16'h0110, 4'd3, 16'hBEEF, 1'b1, 2);
    bubble(3);
    op("lw_wrap", 5'b01101, 4'd4, 4'd0, 16'h0010, 16'h0, 16'h0010, 4'd4, 16'hBEEF, 1'b1, 2);
    op("lw_nomtr", 5'b01001, 4'd10, 4'd0, 16'h7777, 16'h0, 16'h0010, 4'd10, 16'h7777, 1'b1, 2);

    // Reset in the first ACCESS cycle of a store must abort it.
    op("sw_5555", 5'b00010, 4'd1, 4'd0, 16'h0020, 16'h5555, 16'h0020, 4'd1, 16'h0020, 1'b0, 2);
    drive(5'b00010, 4'd1, 4'd0, 16'h0020, 16'hAAAA, 16'h0020);
    @(posedge clk); #1;
    idle_inputs();
    check("abort_busy_pre", {31'd0, mem_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, mem_busy}, 32'd0);
    check("abort_valid", {31'd0, wb_valid}, 32'd0);
    check("abort_regwrite", {31'd0, RegWrite_out}, 32'd0);
    check("abort_reg", {28'd0, wb_reg}, 32'd0);
    check("abort_data", {16'd0, wb_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("lw_5555", 5'b01101, 4'd5, 4'd0, 16'h0020, 16'h0, 16'h0020, 4'd5, 16'h5555, 1'b1, 2);

    // MemRead and MemWrite together: store only, RegWrite suppressed.
    op("conflict", 5'b01011, 4'd6, 4'd0, 16'h0030, 16'h0F0F, 16'h0030, 4'd6, 16'h0030, 1'b0, 2);
    op("lw_0f0f", 5'b01101, 4'd7, 4'd0, 16'h0030, 16'h0, 16'h0030, 4'd7, 16'h0F0F, 1'b1, 2);
    bubble(2);

    // Latency sweep: one store presented to all three instances, then bubbles.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{r: 4'd2, d: 16'h0040, w: 1'b0});
    drive(5'b00010, 4'd2, 4'd0, 16'h0040, 16'h1111, 16'h0040);
    b1 = 0; b2 = 0; b15 = 0; f1 = -1; f2 = -1; f15 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s1_busy === 1'b1) b1++;
      if (mem_busy === 1'b1) b2++;
      if (s15_busy === 1'b1) b15++;
      if (s1_wbv === 1'b1 && f1 < 0) f1 = k;
      if (wb_valid === 1'b1 && f2 < 0) f2 = k;
      if (s15_wbv === 1'b1 && f15 < 0) f15 = k;
      @(posedge clk); #1;
      idle_inputs();
    end
    check("lat1_busy_width", b1, 1);
    check("lat1_wb_cycle", f1, 2);
    check("lat2_busy_width", b2, 2);
    check("lat2_wb_cycle", f2, 3);
    check("lat15_busy_width", b15, 15);
    check("lat15_wb_cycle", f15, 16);

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 256: data-memory words, 16 bits each, addressed by the low 8 bits of lsadr_in.
REQ-002 Parameter MEM_LATENCY, default 2: cycles per memory access; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall_in  in  1  EX/MEM bubble; 1 = no valid instruction this cycle.
REQ-006 RegDst_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in  in  1 each  EX/MEM control bits.
REQ-007 rt_in, rd_in  in  4 each  register specifiers.
REQ-008 result_in  in  16  ALU result.
REQ-009 read_data2_in  in  16  store data.
REQ-010 lsadr_in  in  16  load/store address.
REQ-011 mem_busy  out  1  stall request to IF/ID/EX; upstream holds its outputs while 1.
REQ-012 wb_valid  out  1  MEM/WB entry valid.
REQ-013 RegWrite_out  out  1  register-file write enable, qualified by wb_valid.
REQ-014 wb_reg  out  4  destination register.
REQ-015 wb_data  out  16  write-back value.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE, stall_in=1: next cycle wb_valid=0 and RegWrite_out=0; other outputs hold.
REQ-018 IDLE, stall_in=0, MemRead_in=0, MemWrite_in=0: registered pass-through with 1-cycle latency; wb_valid=1, wb_data=result_in, RegWrite_out=RegWrite_in.
REQ-019 IDLE, stall_in=0, MemRead_in or MemWrite_in set: latch all inputs, load a 4-bit counter with MEM_LATENCY-1, assert mem_busy combinationally in that same cycle, enter ACCESS.
REQ-020 ACCESS: mem_busy=1, wb_valid=0, inputs ignored, counter decrements once per cycle; at counter=0 go to DONE.
REQ-021 Store commit happens only on the ACCESS->DONE edge: mem[lsadr[7:0]] <= latched read_data2.
REQ-022 Load sample happens on the ACCESS->DONE edge from mem[lsadr[7:0]].
REQ-023 DONE, one cycle: wb_valid=1, mem_busy=0, return to IDLE.
REQ-024 A memory op therefore produces its write-back MEM_LATENCY+1 cycles after acceptance.
REQ-025 Upstream holds its outputs for MEM_LATENCY cycles per memory op.
REQ-026 Write-back mux: wb_reg = RegDst ? rd : rt; wb_data = MemtoReg ? loaded word : result; both use latched values.
REQ-027 MemRead=MemWrite=1: store performed, no load; RegWrite_out forced 0.
REQ-028 Addresses wrap modulo 256; lsadr[15:8] ignored.
REQ-029 Store then load to the same address in back-to-back accepted ops: the load returns the new value.
REQ-030 A new instruction is accepted in the DONE cycle only if mem_busy=0; with MEM_LATENCY=1, ACCESS lasts one cycle.

Reset
REQ-031 rst_n=0 forces, asynchronously: state=IDLE, counter=0, mem_busy=0, wb_valid=0, RegWrite_out=0, wb_reg=0, wb_data=0.
REQ-032 Reset during ACCESS aborts the op; a pending store is not committed.
REQ-033 Memory array contents are not reset.

Structure
REQ-034 FSM state encoding, MEM_LATENCY default and address width belong in the shared processor package.
REQ-035 The memory array is a sub-module, data_mem: synchronous write, synchronous read, 256x16.

Verification
REQ-036 Pass-through: result_in=0x1234, RegWrite_in=1, RegDst_in=1, rd_in=5 -> next cycle wb_valid=1, wb_reg=5, wb_data=0x1234, mem_busy=0.
REQ-037 Store/load, MEM_LATENCY=2: sw 0xBEEF to lsadr=0x0110, then lw with MemtoReg=1, rt_in=3 -> mem_busy high 2 cycles per op; lw write-back is wb_reg=3, wb_data=0xBEEF; address 0x10 also holds 0xBEEF.
REQ-038 Bubble: stall_in=1 for 3 cycles -> wb_valid=0 and RegWrite_out=0 all 3 cycles, no memory change.
REQ-039 Reset mid-store: assert rst_n=0 in the first ACCESS cycle of sw 0xAAAA to 0x20 (prior value 0x5555) -> outputs zero immediately; mem[0x20] stays 0x5555.
REQ-040 Conflict: MemRead=MemWrite=1, RegWrite_in=1, data 0x0F0F at 0x30 -> mem[0x30]=0x0F0F, RegWrite_out=0.
REQ-041 Latency sweep: MEM_LATENCY=1 and 15 -> mem_busy width equals MEM_LATENCY, write-back follows exactly one cycle later.
